sha3_padder: RTL
================

SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 SHALL have parameter D, default 512, digest width in bits (224/256/384/512).
REQ-002 SHALL have localparam R = 1600-2*D (rate, bits) and NB = R/8 (bytes per block; 72 at D=512).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_data/in_last/in_void valid.
REQ-006 SHALL have port in_ready  output  1  byte accepted when in_valid & in_ready.
REQ-007 SHALL have port in_data  input  8  message byte.
REQ-008 SHALL have port in_last  input  1  final beat of message.
REQ-009 SHALL have port in_void  input  1  beat carries no byte (legal only with in_last; empty message or empty tail).
REQ-010 SHALL have port out_valid  output  1  out_data holds a complete padded block.
REQ-011 SHALL have port out_ready  input  1  downstream (keccak feeder) takes block.
REQ-012 SHALL have port out_data  output  R  block; message byte i at bits [8i+:8].
REQ-013 SHALL have port out_last  output  1  block is final block of message.

Function
REQ-014 SHALL implement states FILL, EMIT, PADBLK; idx counter 0..NB-1; R-bit buffer; pad_pending flag.
REQ-015 In FILL: in_ready=1, out_valid=0; accepted non-void byte written to buffer byte idx.
REQ-016 Non-last byte, idx<NB-1: idx increments, stay FILL.
REQ-017 Non-last byte, idx==NB-1: go EMIT, out_last=0.
REQ-018 Last byte at idx<NB-1: same cycle write domain byte 0x06 at idx+1, OR 0x80 into byte NB-1, go EMIT, out_last=1.
REQ-019 Last byte at idx==NB-1: go EMIT with out_last=0, set pad_pending.
REQ-020 Void last beat at idx k: write 0x06 at k, OR 0x80 into byte NB-1 (k==NB-1 gives 0x86), go EMIT, out_last=1.
REQ-021 Latency: out_valid asserts the cycle after the completing beat is accepted.
REQ-022 In EMIT: out_valid=1, in_ready=0; out_data/out_last stable until out_ready.
REQ-023 On out_valid & out_ready: buffer cleared to zero, idx=0; pad_pending ? PADBLK : FILL.
REQ-024 PADBLK (one cycle): buffer byte0=0x06, byte NB-1=0x80, clear pad_pending, go EMIT with out_last=1.
REQ-025 Next message starts in FILL at idx 0 immediately after a last block is taken; no gap beyond REQ-023.
REQ-026 in_data ignored when in_void=1; in_void without in_last SHALL be treated as void last (no fault state).

Reset
REQ-027 reset_n low: state=FILL, idx=0, buffer=0, pad_pending=0, out_valid=0, out_last=0; in_ready=1 after release.
REQ-028 Reset mid-message SHALL discard all partial data; no block emitted for it.

Configuration
REQ-029 Macro SHA3_PADDER_XOF_EN: when defined, adds input in_xof (1 bit), sampled with first beat of each message; domain byte 0x1F (SHAKE) when set, 0x06 otherwise; pad-end byte 0x9F when coinciding with 0x80 position.
REQ-030 Without SHA3_PADDER_XOF_EN: no in_xof port, domain byte always 0x06.

Structure
REQ-031 Package sha3_pkg SHALL hold: state enum, constants SHA3_DOMAIN=8'h06, SHAKE_DOMAIN=8'h1F, PAD_END=8'h80, function rate_bits(D).
REQ-032 No sub-module; buffer byte-write logic inline.

Verification (D=512, NB=72)
REQ-033 "abc" (61,62,63 last) -> one block: bytes0-3=61 62 63 06, bytes4-70=00, byte71=80, out_last=1.
REQ-034 Single void last beat -> byte0=06, byte71=80, rest 00, out_last=1.
REQ-035 71 bytes of 0xAA -> one block, bytes0-70=AA, byte71=86, out_last=1.
REQ-036 72 bytes of 0x55 -> block1 all 55, out_last=0; block2 byte0=06, byte71=80, out_last=1.
REQ-037 out_ready low 10 cycles during EMIT -> in_ready=0, out_data unchanged throughout; block taken on first out_ready high.
REQ-038 reset_n pulsed after 30 bytes, then "abc" -> exactly one block, identical to REQ-033.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared SHA-3 padding types and constants.
// Domain/pad bytes, padder state encoding, rate helper.
package sha3_pkg;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PADBLK
  } state_t;

  localparam logic [7:0] SHA3_DOMAIN  = 8'h06;
  localparam logic [7:0] SHAKE_DOMAIN = 8'h1F;
  localparam logic [7:0] PAD_END      = 8'h80;

  function automatic int rate_bits(input int d);
    return 1600 - 2 * d;
  endfunction

endpackage

// File: rtl/sha3_padder.sv
// SHA-3 byte-stream padder: packs bytes into rate-sized blocks.
// Optional SHAKE domain select via SHA3_PADDER_XOF_EN (adds in_xof).
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int D = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  input  logic                     in_void,
`ifdef SHA3_PADDER_XOF_EN
  input  logic                     in_xof,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [rate_bits(D)-1:0]  out_data,
  output logic                     out_last
);

  localparam int R  = rate_bits(D);
  localparam int NB = R / 8;
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST    = IW'(NB - 1);
  localparam logic [IW-1:0] LAST_M1 = IW'(NB - 2);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [R-1:0]    buf_q;
  logic            pad_pending;
  logic            out_last_q;
  logic [7:0]      dom;
  logic [7:0]      dom_pad;

`ifdef SHA3_PADDER_XOF_EN
  logic            in_msg;
  logic            xof_q;

  // First beat of a message picks the domain; later beats reuse it
  assign dom     = (in_msg ? xof_q : in_xof) ? SHAKE_DOMAIN : SHA3_DOMAIN;
  assign dom_pad = xof_q ? SHAKE_DOMAIN : SHA3_DOMAIN;

  // Track message boundaries to latch in_xof on the first beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_msg <= 1'b0;
      xof_q  <= 1'b0;
    end else if (in_valid && state == FILL) begin
      in_msg <= !(in_last || in_void);
      if (!in_msg) xof_q <= in_xof;
    end
  end
`else
  assign dom     = SHA3_DOMAIN;
  assign dom_pad = SHA3_DOMAIN;
`endif

  assign in_ready  = (state == FILL);
  assign out_valid = (state == EMIT);
  assign out_data  = buf_q;
  assign out_last  = out_last_q;

  // Fill/emit/pad-block sequencing with inline byte writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      idx         <= '0;
      buf_q       <= '0;
      pad_pending <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_valid) begin
            if (in_void) begin
              buf_q[8*int'(idx) +: 8] <= dom;
              buf_q[R-8 +: 8] <=
                ((idx == LAST) ? dom : 8'h00) | PAD_END;
              out_last_q <= 1'b1;
              state      <= EMIT;
            end else begin
              buf_q[8*int'(idx) +: 8] <= in_data;
              if (!in_last) begin
                if (idx == LAST) begin
                  out_last_q <= 1'b0;
                  state      <= EMIT;
                end else begin
                  idx <= idx + 1'b1;
                end
              end else if (idx == LAST) begin
                pad_pending <= 1'b1;
                out_last_q  <= 1'b0;
                state       <= EMIT;
              end else begin
                buf_q[8*(int'(idx)+1) +: 8] <= dom;
                buf_q[R-8 +: 8] <=
                  ((idx == LAST_M1) ? dom : 8'h00) | PAD_END;
                out_last_q <= 1'b1;
                state      <= EMIT;
              end
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            buf_q <= '0;
            idx   <= '0;
            state <= pad_pending ? PADBLK : FILL;
          end
        end
        PADBLK: begin
          buf_q[7:0]      <= dom_pad;
          buf_q[R-8 +: 8] <= PAD_END;
          pad_pending     <= 1'b0;
          out_last_q      <= 1'b1;
          state           <= EMIT;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
